// File: rtl/float2int32_iter.sv
// Iterative IEEE-754 single-precision to signed 32-bit integer converter.
// The mantissa is aligned by a multi-cycle shifter that moves SHIFT_STEP bits
// per cycle, then optionally negated. Specials (NaN, inf, overflow, |x|<1)
// finish one cycle after accept.
// Optional macro FLOAT2INT_ROUND_EN: round-to-nearest-even instead of truncation.
module float2int32_iter #(
   parameter int unsigned SHIFT_STEP = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_float,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_int,
   output logic        out_ovf,
   output logic        out_nv
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StShift = 2'd1;
   localparam logic [1:0] StNeg   = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   localparam logic [5:0] Step = 6'(SHIFT_STEP);

   logic [1:0]  state_q, state_d;
   logic [31:0] mag_q, mag_d;
   logic [5:0]  rem_q, rem_d;
   logic        sign_q, sign_d;
   logic        left_q, left_d;
   logic [31:0] res_q, res_d;
   logic        ovf_q, ovf_d;
   logic        nv_q, nv_d;
`ifdef FLOAT2INT_ROUND_EN
   logic        guard_q, guard_d;
   logic        sticky_q, sticky_d;
   logic [31:0] shr_m1;
   logic [31:0] low_mask;
`endif

   logic [7:0]  exp_in;
   logic [22:0] mant_in;
   logic [5:0]  step;
   logic [31:0] rnd;

   assign exp_in  = in_float[30:23];
   assign mant_in = in_float[22:0];

   // Next-state: classification at accept, shifting, rounding/negation, handshake.
   always_comb begin
      state_d = state_q;
      mag_d   = mag_q;
      rem_d   = rem_q;
      sign_d  = sign_q;
      left_d  = left_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      nv_d    = nv_q;
      step    = (rem_q < Step) ? rem_q : Step;
      rnd     = mag_q;
`ifdef FLOAT2INT_ROUND_EN
      guard_d  = guard_q;
      sticky_d = sticky_q;
      shr_m1   = 32'd0;
      low_mask = 32'd0;
      rnd      = mag_q + {31'd0, guard_q & (sticky_q | mag_q[0])};
`endif

      case (state_q)
         StIdle: begin
            if (in_valid) begin
               sign_d = in_float[31];
               ovf_d  = 1'b0;
               nv_d   = 1'b0;
               mag_d  = {8'd0, 1'b1, mant_in};
               rem_d  = 6'd0;
               left_d = 1'b0;
`ifdef FLOAT2INT_ROUND_EN
               guard_d  = 1'b0;
               sticky_d = 1'b0;
`endif
               if (exp_in == 8'hFF && mant_in != 23'd0) begin
                  res_d   = 32'h8000_0000;
                  nv_d    = 1'b1;
                  state_d = StDone;
               end else if (in_float == 32'hCF00_0000) begin
                  // exactly -2^31 is representable, so no overflow flag
                  res_d   = 32'h8000_0000;
                  state_d = StDone;
               end else if (exp_in == 8'hFF || exp_in >= 8'd158) begin
                  res_d   = in_float[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                  ovf_d   = 1'b1;
                  state_d = StDone;
`ifdef FLOAT2INT_ROUND_EN
               end else if (exp_in == 8'd126) begin
                  // 0.5 <= |x| < 1 can round up to 1
                  rem_d   = 6'd24;
                  state_d = StShift;
`endif
               end else if (exp_in < 8'd127) begin
                  res_d   = 32'd0;
                  state_d = StDone;
               end else if (exp_in >= 8'd150) begin
                  left_d  = 1'b1;
                  rem_d   = 6'(exp_in - 8'd150);
                  state_d = (exp_in == 8'd150) ? StNeg : StShift;
               end else begin
                  rem_d   = 6'(8'd150 - exp_in);
                  state_d = StShift;
               end
            end
         end
         StShift: begin
            if (left_q) begin
               mag_d = mag_q << step;
            end else begin
               mag_d = mag_q >> step;
`ifdef FLOAT2INT_ROUND_EN
               // guard is the top dropped bit; everything below folds into sticky
               shr_m1   = mag_q >> (step - 6'd1);
               low_mask = (32'd1 << (step - 6'd1)) - 32'd1;
               guard_d  = shr_m1[0];
               sticky_d = sticky_q | guard_q | ((mag_q & low_mask) != 32'd0);
`endif
            end
            rem_d = rem_q - step;
            if (rem_q == step) begin
               state_d = StNeg;
            end
         end
         StNeg: begin
            res_d   = sign_q ? (~rnd + 32'd1) : rnd;
            state_d = StDone;
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset; reset discards any conversion in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         mag_q    <= 32'd0;
         rem_q    <= 6'd0;
         sign_q   <= 1'b0;
         left_q   <= 1'b0;
         res_q    <= 32'd0;
         ovf_q    <= 1'b0;
         nv_q     <= 1'b0;
`ifdef FLOAT2INT_ROUND_EN
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         mag_q    <= mag_d;
         rem_q    <= rem_d;
         sign_q   <= sign_d;
         left_q   <= left_d;
         res_q    <= res_d;
         ovf_q    <= ovf_d;
         nv_q     <= nv_d;
`ifdef FLOAT2INT_ROUND_EN
         guard_q  <= guard_d;
         sticky_q <= sticky_d;
`endif
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign out_int   = res_q;
   assign out_ovf   = ovf_q;
   assign out_nv    = nv_q;

endmodule

// File: tb/tb_float2int32_iter.sv
// Self-checking bench for float2int32_iter: directed vector table plus
// backpressure and mid-operation reset sequences. SHIFT_STEP = 4.
module tb_float2int32_iter;

   localparam int unsigned ShiftStep = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_float;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_int;
   logic        out_ovf;
   logic        out_nv;

   float2int32_iter #(.SHIFT_STEP(ShiftStep)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_float  (in_float),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_int   (out_int),
      .out_ovf   (out_ovf),
      .out_nv    (out_nv)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] f;
      logic [31:0] res;
      logic        ovf;
      logic        nv;
      int          lat;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [31:0] f, input logic [31:0] res, input logic ovf,
                      input logic nv, input int lat);
      vec_t v;
      v.f = f; v.res = res; v.ovf = ovf; v.nv = nv; v.lat = lat;
      vecs.push_back(v);
   endtask

   // Present one input, return edges from accept (inclusive) until out_valid.
   task automatic convert(input logic [31:0] f, output int lat);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      in_float = f;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      int          lat;
      logic [31:0] held;

      // expected results; latency = ceil(n/4)+2 on shift path, 1 for specials
      add(32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 8);  // 1.0, n=23
      add(32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0, 2);  // 2^23, n=0
      add(32'hC2F6_E979, 32'hFFFF_FF85, 1'b0, 1'b0, 7);  // -123.456, n=17
      add(32'h4020_0000, 32'h0000_0002, 1'b0, 1'b0, 8);  // 2.5, n=22
      add(32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b0, 8);  // -2.5
      add(32'hBF80_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 8);  // -1.0
      add(32'h4B80_0000, 32'h0100_0000, 1'b0, 1'b0, 3);  // 2^24, left n=1
      add(32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 4);  // largest < 2^31, left n=7
      add(32'hCEFF_FFFF, 32'h8000_0080, 1'b0, 1'b0, 4);
      add(32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);  // 2^31 saturates
      add(32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1);  // exactly -2^31
      add(32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1);  // -inf
      add(32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);  // +inf
      add(32'h7FC0_0000, 32'h8000_0000, 1'b0, 1'b1, 1);  // NaN
      add(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1);
      add(32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1);  // -0
      add(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1);  // denormal
`ifdef FLOAT2INT_ROUND_EN
      add(32'h3FC0_0000, 32'h0000_0002, 1'b0, 1'b0, 8);  // 1.5 -> 2
      add(32'h3FFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, 8);
      add(32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b0, 8);  // 0.5 ties to even
      add(32'h3F40_0000, 32'h0000_0001, 1'b0, 1'b0, 8);  // 0.75 -> 1
      add(32'hBF40_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 8);
`else
      add(32'h3FC0_0000, 32'h0000_0001, 1'b0, 1'b0, 8);  // 1.5 -> 1
      add(32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 8);
      add(32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b0, 1);
      add(32'h3F40_0000, 32'h0000_0000, 1'b0, 1'b0, 1);
      add(32'hBF40_0000, 32'h0000_0000, 1'b0, 1'b0, 1);
`endif

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_float  = 32'd0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset out_int", out_int, 32'd0);
      chk("reset flags", {30'd0, out_ovf, out_nv}, 32'd0);

      foreach (vecs[i]) begin
         convert(vecs[i].f, lat);
         chk($sformatf("latency %h", vecs[i].f), 32'(lat), 32'(vecs[i].lat));
         chk($sformatf("out_int %h", vecs[i].f), out_int, vecs[i].res);
         chk($sformatf("flags %h", vecs[i].f), {30'd0, out_ovf, out_nv},
             {30'd0, vecs[i].ovf, vecs[i].nv});
         drain();
         chk($sformatf("idle handshake %h", vecs[i].f), {30'd0, in_ready, out_valid},
             {30'd0, 1'b1, 1'b0});
         chk($sformatf("idle hold %h", vecs[i].f), out_int, vecs[i].res);
      end

      // Backpressure: result held for 5 cycles while next input waits with in_valid high.
      convert(32'h4B00_0000, lat);
      in_float = 32'h3F80_0000;
      in_valid = 1'b1;
      held = out_int;
      chk("bp result", held, 32'h0080_0000);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk($sformatf("bp stall %0d", c),
             {29'd0, out_valid, in_ready, out_ovf | out_nv}, {29'd0, 1'b1, 1'b0, 1'b0});
         chk($sformatf("bp hold %0d", c), out_int, held);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp release", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp reaccept", {31'd0, in_ready}, 32'd0);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("bp second latency", 32'(lat), 32'd8);
      chk("bp second result", out_int, 32'h0000_0001);
      drain();

      // Reset during SHIFT aborts the conversion and clears the output.
      in_float = 32'h3F80_0000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort state", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
      chk("abort out_int", out_int, 32'd0);
      lat = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (out_valid) lat++;
      end
      chk("abort no output", 32'(lat), 32'd0);
      convert(32'hC2F6_E979, lat);
      chk("post-reset latency", 32'(lat), 32'd7);
      chk("post-reset result", out_int, 32'hFFFF_FF85);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
